reorder_buffer: RTL and testbench

//  Circular reorder buffer directly downstream of register_file. Accepts one

---
 rtl/reorder_buffer_pkg.sv | 41 ++++
 rtl/reorder_buffer_fwd.sv | 29 ++
 rtl/reorder_buffer.sv | 196 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - widths, tag wrap helper and output records for the reorder buffer
package reorder_buffer_pkg;
    localparam int ROB_BIT   = 4;
    localparam int REG_BIT   = 5;
    localparam int DAT_W     = 32;
    localparam int RAM_ADR_W = 32;
    localparam int OP_W      = 6;
    localparam int ROB_S     = 2 ** ROB_BIT;

    typedef logic [ROB_BIT-1:0] rob_tag_t;

    localparam rob_tag_t TAG_FIRST = rob_tag_t'(1);
    localparam rob_tag_t TAG_LAST  = rob_tag_t'(ROB_S - 1);
    localparam rob_tag_t FULL_MARK = rob_tag_t'(ROB_S - 2);

    // Tag 0 means "no producer", so the wrap skips it.
    function automatic rob_tag_t rob_next(input rob_tag_t t);
        return (t == TAG_LAST) ? TAG_FIRST : t + rob_tag_t'(1);
    endfunction

    typedef struct packed {
        logic                 en;
        logic                 ic;
        logic                 ls;
        logic [OP_W-1:0]      op;
        logic [DAT_W-1:0]     imm;
        logic [RAM_ADR_W-1:0] pc;
        logic [ROB_BIT-1:0]   qd;
        logic [ROB_BIT-1:0]   qj;
        logic [ROB_BIT-1:0]   qk;
        logic [DAT_W-1:0]     vj;
        logic [DAT_W-1:0]     vk;
    } rs_out_t;

    typedef struct packed {
        logic               en;
        logic [REG_BIT-1:0] rd;
        logic [ROB_BIT-1:0] q;
        logic [DAT_W-1:0]   v;
    } cm_out_t;
endpackage

// File: rtl/reorder_buffer_fwd.sv
// rtl/reorder_buffer_fwd.sv - single-operand resolver: RF value, CDB bypass, then completed entry
module reorder_buffer_fwd
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_BIT-1:0]     q,
    input  logic [DAT_W-1:0]       v,
    input  logic                   cdb_en,
    input  logic [ROB_BIT-1:0]     cdb_q,
    input  logic [DAT_W-1:0]       cdb_v,
    input  logic [ROB_S-1:0]       ent_ready,
    input  logic [ROB_S*DAT_W-1:0] ent_val,
    output logic [ROB_BIT-1:0]     res_q,
    output logic [DAT_W-1:0]       res_v
);
    always_comb begin
        res_q = q;
        res_v = v;
        if (q == '0) begin
            res_q = '0;
            res_v = v;
        end else if (cdb_en && (cdb_q == q)) begin
            res_q = '0;
            res_v = cdb_v;
        end else if (ent_ready[q]) begin
            res_q = '0;
            res_v = ent_val[32'(q)*DAT_W +: DAT_W];
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer: tag allocation, operand resolve, in-order commit
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush_i,
    input  logic                 rf_en_i,
    input  logic                 rf_ic_i,
    input  logic                 rf_ls_i,
    input  logic [REG_BIT-1:0]   rf_rd_i,
    input  logic [ROB_BIT-1:0]   rf_qd_i,
    input  logic [ROB_BIT-1:0]   rf_qj_i,
    input  logic [ROB_BIT-1:0]   rf_qk_i,
    input  logic [DAT_W-1:0]     rf_vj_i,
    input  logic [DAT_W-1:0]     rf_vk_i,
    input  logic [OP_W-1:0]      rf_op_i,
    input  logic [DAT_W-1:0]     rf_imm_i,
    input  logic [RAM_ADR_W-1:0] rf_pc_i,
    output logic [ROB_BIT-1:0]   rob_qd_o,
    output logic                 full_o,
    input  logic                 cdb_en_i,
    input  logic [ROB_BIT-1:0]   cdb_q_i,
    input  logic [DAT_W-1:0]     cdb_v_i,
    output logic                 rs_en_o,
    output logic                 rs_ic_o,
    output logic                 rs_ls_o,
    output logic [OP_W-1:0]      rs_op_o,
    output logic [DAT_W-1:0]     rs_imm_o,
    output logic [RAM_ADR_W-1:0] rs_pc_o,
    output logic [ROB_BIT-1:0]   rs_qd_o,
    output logic [ROB_BIT-1:0]   rs_qj_o,
    output logic [ROB_BIT-1:0]   rs_qk_o,
    output logic [DAT_W-1:0]     rs_vj_o,
    output logic [DAT_W-1:0]     rs_vk_o,
    output logic                 cm_en_o,
    output logic [REG_BIT-1:0]   cm_rd_o,
    output logic [ROB_BIT-1:0]   cm_q_o,
    output logic [DAT_W-1:0]     cm_v_o
);
    rob_tag_t               head;
    rob_tag_t               tail;
    rob_tag_t               count;
    rob_tag_t               count_nxt;
    logic [ROB_S-1:0]       busy;
    logic [ROB_S-1:0]       ready;
    logic [REG_BIT-1:0]     ent_rd [ROB_S];
    logic [ROB_S*DAT_W-1:0] ent_val;

    logic                   flush_now;
    logic                   do_issue;
    logic                   do_commit;
    logic                   do_cdb;
    rob_tag_t               res_qj;
    rob_tag_t               res_qk;
    logic [DAT_W-1:0]       res_vj;
    logic [DAT_W-1:0]       res_vk;
    rs_out_t                rs_r;
    cm_out_t                cm_r;

    reorder_buffer_fwd u_fwd_j (
        .q         (rf_qj_i),
        .v         (rf_vj_i),
        .cdb_en    (cdb_en_i),
        .cdb_q     (cdb_q_i),
        .cdb_v     (cdb_v_i),
        .ent_ready (ready),
        .ent_val   (ent_val),
        .res_q     (res_qj),
        .res_v     (res_vj)
    );

    reorder_buffer_fwd u_fwd_k (
        .q         (rf_qk_i),
        .v         (rf_vk_i),
        .cdb_en    (cdb_en_i),
        .cdb_q     (cdb_q_i),
        .cdb_v     (cdb_v_i),
        .ent_ready (ready),
        .ent_val   (ent_val),
        .res_q     (res_qk),
        .res_v     (res_vk)
    );

    // The count==N-1 guard drops an issue that would land on the busy head entry.
    always_comb begin
        flush_now = en && flush_i;
        do_issue  = en && !flush_i && rf_en_i && (count != TAG_LAST);
        do_commit = en && !flush_i && busy[head] && ready[head];
        do_cdb    = en && !flush_i && cdb_en_i && (cdb_q_i != '0) && busy[cdb_q_i];
    end

    always_comb begin
        count_nxt = count;
        if (do_issue && !do_commit) begin
            count_nxt = count + rob_tag_t'(1);
        end else if (!do_issue && do_commit) begin
            count_nxt = count - rob_tag_t'(1);
        end
    end

    // Order matters: a commit clears after any CDB write to the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= TAG_FIRST;
            tail   <= TAG_FIRST;
            count  <= '0;
            busy   <= '0;
            ready  <= '0;
            full_o <= 1'b0;
        end else if (flush_now) begin
            head   <= TAG_FIRST;
            tail   <= TAG_FIRST;
            count  <= '0;
            busy   <= '0;
            ready  <= '0;
            full_o <= 1'b0;
        end else if (en) begin
            if (do_cdb) begin
                ready[cdb_q_i] <= 1'b1;
            end
            if (do_commit) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
                head        <= rob_next(head);
            end
            if (do_issue) begin
                busy[rf_qd_i]  <= 1'b1;
                ready[rf_qd_i] <= 1'b0;
                tail           <= rob_next(tail);
            end
            count  <= count_nxt;
            full_o <= (count_nxt >= FULL_MARK);
        end
    end

    always_ff @(posedge clk) begin
        if (do_cdb) begin
            ent_val[32'(cdb_q_i)*DAT_W +: DAT_W] <= cdb_v_i;
        end
        if (do_issue) begin
            ent_rd[rf_qd_i] <= rf_rd_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_r <= '0;
            cm_r <= '0;
        end else if (flush_now) begin
            rs_r <= '0;
            cm_r <= '0;
        end else if (!en) begin
            rs_r.en <= 1'b0;
            cm_r.en <= 1'b0;
        end else begin
            rs_r.en <= do_issue;
            if (do_issue) begin
                rs_r.ic  <= rf_ic_i;
                rs_r.ls  <= rf_ls_i;
                rs_r.op  <= rf_op_i;
                rs_r.imm <= rf_imm_i;
                rs_r.pc  <= rf_pc_i;
                rs_r.qd  <= rf_qd_i;
                rs_r.qj  <= res_qj;
                rs_r.qk  <= res_qk;
                rs_r.vj  <= res_vj;
                rs_r.vk  <= res_vk;
            end
            cm_r.en <= do_commit;
            if (do_commit) begin
                cm_r.rd <= ent_rd[head];
                cm_r.q  <= head;
                cm_r.v  <= ent_val[32'(head)*DAT_W +: DAT_W];
            end
        end
    end

    assign rob_qd_o = tail;
    assign rs_en_o  = rs_r.en;
    assign rs_ic_o  = rs_r.ic;
    assign rs_ls_o  = rs_r.ls;
    assign rs_op_o  = rs_r.op;
    assign rs_imm_o = rs_r.imm;
    assign rs_pc_o  = rs_r.pc;
    assign rs_qd_o  = rs_r.qd;
    assign rs_qj_o  = rs_r.qj;
    assign rs_qk_o  = rs_r.qk;
    assign rs_vj_o  = rs_r.vj;
    assign rs_vk_o  = rs_r.vk;
    assign cm_en_o  = cm_r.en;
    assign cm_rd_o  = cm_r.rd;
    assign cm_q_o   = cm_r.q;
    assign cm_v_o   = cm_r.v;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and random checks of reorder_buffer against a program-order queue model
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 flush_i;
    logic                 rf_en_i;
    logic                 rf_ic_i;
    logic                 rf_ls_i;
    logic [REG_BIT-1:0]   rf_rd_i;
    logic [ROB_BIT-1:0]   rf_qd_i;
    logic [ROB_BIT-1:0]   rf_qj_i;
    logic [ROB_BIT-1:0]   rf_qk_i;
    logic [DAT_W-1:0]     rf_vj_i;
    logic [DAT_W-1:0]     rf_vk_i;
    logic [OP_W-1:0]      rf_op_i;
    logic [DAT_W-1:0]     rf_imm_i;
    logic [RAM_ADR_W-1:0] rf_pc_i;
    logic [ROB_BIT-1:0]   rob_qd_o;
    logic                 full_o;
    logic                 cdb_en_i;
    logic [ROB_BIT-1:0]   cdb_q_i;
    logic [DAT_W-1:0]     cdb_v_i;
    logic                 rs_en_o;
    logic                 rs_ic_o;
    logic                 rs_ls_o;
    logic [OP_W-1:0]      rs_op_o;
    logic [DAT_W-1:0]     rs_imm_o;
    logic [RAM_ADR_W-1:0] rs_pc_o;
    logic [ROB_BIT-1:0]   rs_qd_o;
    logic [ROB_BIT-1:0]   rs_qj_o;
    logic [ROB_BIT-1:0]   rs_qk_o;
    logic [DAT_W-1:0]     rs_vj_o;
    logic [DAT_W-1:0]     rs_vk_o;
    logic                 cm_en_o;
    logic [REG_BIT-1:0]   cm_rd_o;
    logic [ROB_BIT-1:0]   cm_q_o;
    logic [DAT_W-1:0]     cm_v_o;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
        .rf_en_i(rf_en_i), .rf_ic_i(rf_ic_i), .rf_ls_i(rf_ls_i), .rf_rd_i(rf_rd_i),
        .rf_qd_i(rf_qd_i), .rf_qj_i(rf_qj_i), .rf_qk_i(rf_qk_i),
        .rf_vj_i(rf_vj_i), .rf_vk_i(rf_vk_i), .rf_op_i(rf_op_i),
        .rf_imm_i(rf_imm_i), .rf_pc_i(rf_pc_i), .rob_qd_o(rob_qd_o), .full_o(full_o),
        .cdb_en_i(cdb_en_i), .cdb_q_i(cdb_q_i), .cdb_v_i(cdb_v_i),
        .rs_en_o(rs_en_o), .rs_ic_o(rs_ic_o), .rs_ls_o(rs_ls_o), .rs_op_o(rs_op_o),
        .rs_imm_o(rs_imm_o), .rs_pc_o(rs_pc_o), .rs_qd_o(rs_qd_o),
        .rs_qj_o(rs_qj_o), .rs_qk_o(rs_qk_o), .rs_vj_o(rs_vj_o), .rs_vk_o(rs_vk_o),
        .cm_en_o(cm_en_o), .cm_rd_o(cm_rd_o), .cm_q_o(cm_q_o), .cm_v_o(cm_v_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        int          rd;
        bit          done;
        logic [31:0] val;
    } ent_t;

    ent_t mq[$];
    int   m_tail = 1;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_tag(input int t);
        return (t % (ROB_S - 1)) + 1;
    endfunction

    task automatic resolve(input int q, input logic [31:0] v, output int rq, output logic [31:0] rv);
        rq = q;
        rv = v;
        if (q == 0) begin
            rq = 0;
        end else if (cdb_en_i && int'(cdb_q_i) == q) begin
            rq = 0;
            rv = cdb_v_i;
        end else begin
            foreach (mq[i]) if (mq[i].tag == q && mq[i].done) begin
                rq = 0;
                rv = mq[i].val;
            end
        end
    endtask

    function automatic int pick_tag();
        if (mq.size() == 0 || $urandom_range(0, 1) == 0) return 0;
        return mq[$urandom_range(0, mq.size() - 1)].tag;
    endfunction

    task automatic set_idle();
        en = 1'b1; flush_i = 1'b0; rf_en_i = 1'b0; cdb_en_i = 1'b0;
        rf_qj_i = '0; rf_qk_i = '0;
    endtask

    task automatic rand_issue();
        rf_en_i  = 1'b1;
        rf_rd_i  = REG_BIT'($urandom);
        rf_ic_i  = 1'($urandom_range(0, 1));
        rf_ls_i  = 1'($urandom_range(0, 1));
        rf_op_i  = OP_W'($urandom);
        rf_imm_i = $urandom;
        rf_pc_i  = $urandom;
        rf_vj_i  = $urandom;
        rf_vk_i  = $urandom;
        rf_qj_i  = ROB_BIT'(pick_tag());
        rf_qk_i  = ROB_BIT'(pick_tag());
    endtask

    task automatic set_cdb(input int q, input logic [31:0] v);
        cdb_en_i = 1'b1; cdb_q_i = ROB_BIT'(q); cdb_v_i = v;
    endtask

    // One clock: predict from the queue before the edge, update it after, compare.
    task automatic step();
        bit          e_rs, e_cm;
        int          e_qj, e_qk;
        logic [31:0] e_vj, e_vk;
        ent_t        e_c, ne;
        logic [ROB_BIT-1:0] it_tag;
        e_rs = 0; e_cm = 0; e_qj = 0; e_qk = 0; e_vj = 0; e_vk = 0;
        rf_qd_i = ROB_BIT'(m_tail);
        it_tag  = ROB_BIT'(m_tail);
        if (en && !flush_i) begin
            if (mq.size() > 0 && mq[0].done) begin
                e_cm = 1; e_c = mq[0];
            end
            resolve(int'(rf_qj_i), rf_vj_i, e_qj, e_vj);
            resolve(int'(rf_qk_i), rf_vk_i, e_qk, e_vk);
            e_rs = rf_en_i && (mq.size() < ROB_S - 1);
        end
        @(posedge clk);
        #1;
        if (en && flush_i) begin
            mq.delete();
            m_tail = 1;
        end else if (en) begin
            if (e_cm) void'(mq.pop_front());
            if (cdb_en_i && cdb_q_i != '0)
                foreach (mq[i]) if (mq[i].tag == int'(cdb_q_i)) begin
                    mq[i].done = 1; mq[i].val = cdb_v_i;
                end
            if (e_rs) begin
                ne.tag = m_tail; ne.rd = int'(rf_rd_i); ne.done = 0; ne.val = '0;
                mq.push_back(ne);
                m_tail = next_tag(m_tail);
            end
        end
        check("rob_qd", 64'(rob_qd_o), 64'(m_tail));
        check("full", 64'(full_o), 64'(mq.size() >= ROB_S - 2));
        check("rs_en", 64'(rs_en_o), 64'(e_rs));
        check("cm_en", 64'(cm_en_o), 64'(e_cm));
        if (e_rs) begin
            check("rs_misc", 64'({rs_ic_o, rs_ls_o, rs_op_o, rs_qd_o}), 64'({rf_ic_i, rf_ls_i, rf_op_i, it_tag}));
            check("rs_imm_pc", {rs_imm_o, rs_pc_o}, {rf_imm_i, rf_pc_i});
            check("rs_j", {28'(0), rs_qj_o, rs_vj_o}, {28'(0), ROB_BIT'(e_qj), e_vj});
            check("rs_k", {28'(0), rs_qk_o, rs_vk_o}, {28'(0), ROB_BIT'(e_qk), e_vk});
        end
        if (e_cm) begin
            check("cm_rd_q", 64'({cm_rd_o, cm_q_o}), 64'({REG_BIT'(e_c.rd), ROB_BIT'(e_c.tag)}));
            check("cm_v", 64'(cm_v_o), 64'(e_c.val));
        end
        if (en && flush_i) begin
            check("flush_out", {cm_v_o, rs_vj_o}, 64'(0));
        end
    endtask

    task automatic mid_reset();
        set_idle();
        rst = 1'b1;
        #1;
        check("rst_rob_qd", 64'(rob_qd_o), 64'(1));
        check("rst_full", 64'(full_o), 64'(0));
        check("rst_cm_en", 64'(cm_en_o), 64'(0));
        mq.delete();
        m_tail = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        rf_rd_i = '0; rf_ic_i = 1'b0; rf_ls_i = 1'b0; rf_op_i = '0; rf_imm_i = '0;
        rf_pc_i = '0; rf_vj_i = '0; rf_vk_i = '0; rf_qd_i = '0; cdb_q_i = '0; cdb_v_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset mid-stream
        for (int i = 0; i < 3; i++) begin rand_issue(); step(); end
        set_cdb(1, 32'h11); rf_en_i = 1'b0; step();
        mid_reset();

        // single issue then CDB, commit two cycles later
        set_idle();
        rand_issue(); rf_rd_i = 5; rf_qj_i = '0; rf_qk_i = '0; step();
        set_idle(); set_cdb(1, 32'h2A); step();
        set_idle(); step(); step(); step();

        // same-cycle CDB bypass into dispatch
        rand_issue(); rf_qj_i = 4'd1; rf_vj_i = 32'hDEAD; rf_qk_i = '0; set_cdb(1, 32'h7); step();
        set_idle(); step();
        flush_i = 1'b1; step(); set_idle();

        // fill, full flag, tag wrap and dropped overflow issue
        for (int i = 0; i < 16; i++) begin rand_issue(); step(); end
        set_idle(); step();
        flush_i = 1'b1; step(); set_idle();

        // out-of-order completion, in-order commit
        for (int i = 0; i < 3; i++) begin rand_issue(); step(); end
        set_idle(); set_cdb(1, 32'hA1); step();
        set_idle(); set_cdb(3, 32'hA3); step();
        set_idle(); step(); step(); step();
        set_cdb(2, 32'hA2); step();
        set_idle(); step(); step(); step(); step();

        // flush beats a simultaneous CDB and issue
        flush_i = 1'b1; step(); set_idle();
        for (int i = 0; i < 5; i++) begin rand_issue(); step(); end
        set_idle(); set_cdb(1, 32'h55); flush_i = 1'b1; rand_issue(); step();
        set_idle(); step();

        // random traffic
        for (int c = 0; c < 1200; c++) begin
            set_idle();
            en      = ($urandom_range(0, 9) != 0);
            flush_i = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) < 6) rand_issue();
            if ($urandom_range(0, 9) < 5) begin
                if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                    set_cdb(mq[$urandom_range(0, mq.size() - 1)].tag, $urandom);
                else
                    set_cdb(int'($urandom_range(0, ROB_S - 1)), $urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
